acq_frame_streamer: RTL and testbench
=====================================

ACQ_FRAME_STREAMER -- requirements
Module: acq_frame_streamer

Interface
REQ-001 The block SHALL take parameter DATA_W, default 14, as the ADC sample width.
REQ-002 The block SHALL take parameter DEPTH, default 1024, as the maximum samples per frame; ADDR_W = clog2(DEPTH).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high. The ports are:
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- wr_valid  in  1  a sample is presented this cycle.
- wr_data  in  DATA_W  sample value from the sampler.
- frame_done  in  1  one-cycle pulse that closes the current frame.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer accepts the word.
- m_data  out  16  header or sample word.
- m_first  out  1  marks the header word.
- m_last  out  1  marks the final sample of the frame.
- overflow  out  1  sticky; a sample or frame was dropped.
- busy  out  1  at least one bank is full or streaming.

Function
REQ-004 Storage SHALL be two banks (ping-pong) of DEPTH x DATA_W, with a writer and a reader that operate concurrently.
REQ-005 Writer states SHALL be FILL and STALL.
- In FILL, wr_valid writes wr_data to the active bank at wr_addr, then wr_addr increments.
- The write count saturates at DEPTH.
- A write at count = DEPTH is discarded and sets overflow.
REQ-006 On frame_done in FILL with count > 0:
- The bank is marked full with length = count.
- If wr_valid is high in the same cycle, that sample is included before the close.
- If the other bank is empty, the writer switches to it next cycle with count = 0; otherwise it enters STALL.
REQ-007 frame_done with count = 0 SHALL be ignored; no frame is issued.
REQ-008 In STALL:
- wr_valid samples are discarded and set overflow.
- frame_done is ignored.
- The writer returns to FILL on the other bank the cycle after that bank is freed.
REQ-009 Reader states SHALL be IDLE, HEADER, PREFETCH, STREAM and RELEASE.
- Reader transitions: IDLE -> HEADER when the next bank in order is full; HEADER -> PREFETCH on the header handshake; PREFETCH -> STREAM after the 1-cycle RAM read; STREAM -> RELEASE on the last-sample handshake; RELEASE -> IDLE.
- Banks are served in completion order, strictly alternating.
REQ-010 The header word SHALL be {seq[4:0], len[10:0]}, with m_first = 1.
- len = sample count, range 1..1024.
- seq is a 5-bit frame counter that increments per issued frame and wraps 31 -> 0.
REQ-011 A sample word SHALL be {2'b00, sample}, zero-extended.
- m_last = 1 only on sample index len-1.
- For len = 1 the single sample carries m_last.
REQ-012 Handshake: a transfer occurs when m_valid && m_ready.
- While m_valid is high and m_ready is low, m_data, m_first and m_last SHALL hold stable.
- m_valid SHALL NOT drop without a transfer.
REQ-013 After the initial PREFETCH, the reader SHALL sustain one word per cycle while m_ready = 1, using a prefetch/skid register.
REQ-014 In RELEASE, the bank SHALL be marked empty; a stalled writer may resume on it the following cycle.
REQ-015 Latency: the header SHALL be valid no later than 2 cycles after the frame_done that closes the frame, when the reader is IDLE.
REQ-016 busy SHALL be high when either bank is full or the reader is not IDLE.

Reset
REQ-017 Reset SHALL:
- clear both bank flags, wr_addr, counts and seq;
- clear overflow;
- set m_valid = 0, m_first = 0, m_last = 0, m_data = 0;
- put the writer in FILL on bank 0 and the reader in IDLE.
REQ-018 Reset asserted mid-frame or mid-stream SHALL abandon all data; there are no partial frames after reset. RAM contents need not be cleared.

Structure
REQ-019 Package acq_pkg SHALL hold DATA_W, DEPTH and ADDR_W defaults, the writer and reader state enums, and the header field widths.
REQ-020 Each bank SHALL be an instance of sub-module acq_bank_ram: simple dual-port, 1 write port, 1 registered read port, 1-cycle read latency.

Verification
REQ-021 Basic frame: write 4 samples 0x0001..0x0004, then frame_done, with m_ready = 1 -> words 0x0004 (first), 0x0001, 0x0002, 0x0003, 0x0004 (last).
REQ-022 Backpressure: same frame with m_ready toggling 1/0 each cycle -> identical word sequence, outputs stable while stalled, no loss.
REQ-023 Ping-pong overflow:
- Stimulus: three 8-sample frames back-to-back with m_ready = 0.
- Required: frames seq 0 and 1 are stored and the third frame's samples are dropped with overflow = 1.
- After m_ready = 1: two frames emitted with headers 0x0008 and 0x0808.
REQ-024 Boundaries:
- 1025 writes then frame_done -> header 0x0400, 1024 samples, overflow = 1.
- frame_done with 0 samples -> no output.
- len = 1 -> the single sample has m_last.
REQ-025 Reset mid-stream: assert reset during sample 3 of 8 -> m_valid = 0 next cycle, busy = 0, and the next frame has header seq 0.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition frame streamer.
//   - Default sample width, frame depth and address width.
//   - Writer and reader state encodings.
//   - Header field widths and the header packing helper.
package acq_pkg;

   localparam int ACQ_DATA_W = 14;
   localparam int ACQ_DEPTH  = 1024;
   localparam int ACQ_ADDR_W = $clog2(ACQ_DEPTH);

   // Header word = {seq, len}; both fields together fill the 16-bit stream word.
   localparam int ACQ_SEQ_W  = 5;
   localparam int ACQ_LEN_W  = 11;
   localparam int ACQ_WORD_W = 16;

   typedef enum logic {
      WR_FILL  = 1'b0,
      WR_STALL = 1'b1
   } wr_state_e;

   typedef enum logic [2:0] {
      RD_IDLE     = 3'd0,
      RD_HEADER   = 3'd1,
      RD_PREFETCH = 3'd2,
      RD_STREAM   = 3'd3,
      RD_RELEASE  = 3'd4
   } rd_state_e;

   function automatic logic [ACQ_WORD_W-1:0] make_header(
      input logic [ACQ_SEQ_W-1:0] seq,
      input logic [ACQ_LEN_W-1:0] len
   );
      return {seq, len};
   endfunction

endpackage

// File: rtl/acq_bank_ram.sv
// One sample bank: simple dual-port RAM with a single write port and a
// registered read port (read data appears one cycle after the address).
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address, sampled every cycle
//   rdata_o  : registered read data
module acq_bank_ram
   import acq_pkg::*;
#(
   parameter int DATA_W = ACQ_DATA_W,
   parameter int DEPTH  = ACQ_DEPTH,
   parameter int ADDR_W = ACQ_ADDR_W
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/acq_frame_streamer.sv
// Ping-pong frame buffer between an ADC sampler and a ready/valid consumer.
// The writer fills one bank while the reader streams the other; each frame
// goes out as a header word {seq, len} followed by len zero-extended samples.
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-high
//   wr_valid   : sample present on wr_data
//   wr_data    : sample value
//   frame_done : one-cycle pulse closing the current frame
//   m_valid    : m_data valid
//   m_ready    : consumer accepts the word
//   m_data     : header or sample word
//   m_first    : header marker
//   m_last     : final sample marker
//   overflow   : sticky, a sample or frame was dropped
//   busy       : a bank is full or the reader is active
module acq_frame_streamer
   import acq_pkg::*;
#(
   parameter int DATA_W = ACQ_DATA_W,
   parameter int DEPTH  = ACQ_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              frame_done,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [15:0]       m_data,
   output logic              m_first,
   output logic              m_last,
   output logic              overflow,
   output logic              busy
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   // Writer state
   wr_state_e                 wr_state_q, wr_state_d;
   logic                      wr_bank_q, wr_bank_d;
   logic [CNT_W-1:0]          wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]          wr_cnt_eff;
   logic                      wr_we;

   // Bank bookkeeping, shared by writer (sets) and reader (clears)
   logic [1:0]                full_q, full_d;
   logic [1:0][CNT_W-1:0]     len_q, len_d;
   logic                      overflow_q, overflow_d;

   // Reader state
   rd_state_e                 rd_state_q, rd_state_d;
   logic                      rd_bank_q, rd_bank_d;
   logic [ACQ_SEQ_W-1:0]      seq_q, seq_d;
   logic [ADDR_W-1:0]         ptr_q, ptr_d;
   logic                      m_valid_q, m_valid_d;
   logic [15:0]               m_data_q, m_data_d;
   logic                      m_first_q, m_first_d;
   logic                      m_last_q, m_last_d;

   logic [DATA_W-1:0]         rdata0, rdata1, rd_sample;
   logic [CNT_W-1:0]          rd_len;
   logic                      other_bank, other_free, releasing;

   acq_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
      .clk_i   (clk),
      .we_i    (wr_we && !wr_bank_q),
      .waddr_i (wr_cnt_q[ADDR_W-1:0]),
      .wdata_i (wr_data),
      .raddr_i (ptr_d),
      .rdata_o (rdata0)
   );

   acq_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
      .clk_i   (clk),
      .we_i    (wr_we && wr_bank_q),
      .waddr_i (wr_cnt_q[ADDR_W-1:0]),
      .wdata_i (wr_data),
      .raddr_i (ptr_d),
      .rdata_o (rdata1)
   );

   assign rd_sample  = rd_bank_q ? rdata1 : rdata0;
   assign rd_len     = len_q[rd_bank_q];
   assign other_bank = ~wr_bank_q;
   assign releasing  = (rd_state_q == RD_RELEASE);
   // A bank being released this cycle counts as free so a stalled writer
   // resumes on it in the very next cycle.
   assign other_free = !full_q[other_bank] || (releasing && (rd_bank_q == other_bank));

   always_comb begin
      wr_state_d = wr_state_q;
      wr_bank_d  = wr_bank_q;
      wr_cnt_d   = wr_cnt_q;
      wr_cnt_eff = wr_cnt_q;
      wr_we      = 1'b0;
      full_d     = full_q;
      len_d      = len_q;
      overflow_d = overflow_q;

      unique case (wr_state_q)
         WR_FILL: begin
            if (wr_valid) begin
               if (wr_cnt_q < CNT_MAX) begin
                  wr_we      = 1'b1;
                  wr_cnt_eff = wr_cnt_q + CNT_W'(1);
               end else begin
                  overflow_d = 1'b1;
               end
            end
            wr_cnt_d = wr_cnt_eff;
            // A sample arriving with frame_done is part of the frame it closes.
            if (frame_done && (wr_cnt_eff != '0)) begin
               full_d[wr_bank_q] = 1'b1;
               len_d[wr_bank_q]  = wr_cnt_eff;
               if (other_free) begin
                  wr_bank_d = other_bank;
                  wr_cnt_d  = '0;
               end else begin
                  wr_state_d = WR_STALL;
               end
            end
         end
         WR_STALL: begin
            if (wr_valid) overflow_d = 1'b1;
            if (other_free) begin
               wr_state_d = WR_FILL;
               wr_bank_d  = other_bank;
               wr_cnt_d   = '0;
            end
         end
         default: wr_state_d = WR_FILL;
      endcase
   end

   // ptr_d drives the RAM read address, so rd_sample always equals the word
   // at ptr_q; advancing ptr on each load keeps the next sample prefetched.
   always_comb begin
      rd_state_d = rd_state_q;
      rd_bank_d  = rd_bank_q;
      seq_d      = seq_q;
      ptr_d      = ptr_q;
      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;
      m_first_d  = m_first_q;
      m_last_d   = m_last_q;

      unique case (rd_state_q)
         RD_IDLE: begin
            if (full_q[rd_bank_q]) begin
               m_valid_d  = 1'b1;
               m_first_d  = 1'b1;
               m_last_d   = 1'b0;
               m_data_d   = make_header(seq_q, ACQ_LEN_W'(rd_len));
               ptr_d      = '0;
               rd_state_d = RD_HEADER;
            end
         end
         RD_HEADER: begin
            if (m_ready) begin
               m_valid_d  = 1'b0;
               m_first_d  = 1'b0;
               rd_state_d = RD_PREFETCH;
            end
         end
         RD_PREFETCH: begin
            m_valid_d  = 1'b1;
            m_first_d  = 1'b0;
            m_data_d   = ACQ_WORD_W'(rd_sample);
            m_last_d   = ({1'b0, ptr_q} == (rd_len - CNT_W'(1)));
            ptr_d      = ptr_q + ADDR_W'(1);
            rd_state_d = RD_STREAM;
         end
         RD_STREAM: begin
            if (m_ready) begin
               if (m_last_q) begin
                  m_valid_d  = 1'b0;
                  m_last_d   = 1'b0;
                  rd_state_d = RD_RELEASE;
               end else begin
                  m_data_d = ACQ_WORD_W'(rd_sample);
                  m_last_d = ({1'b0, ptr_q} == (rd_len - CNT_W'(1)));
                  ptr_d    = ptr_q + ADDR_W'(1);
               end
            end
         end
         RD_RELEASE: begin
            rd_bank_d  = ~rd_bank_q;
            seq_d      = seq_q + ACQ_SEQ_W'(1);
            ptr_d      = '0;
            rd_state_d = RD_IDLE;
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_state_q <= WR_FILL;
         wr_bank_q  <= 1'b0;
         wr_cnt_q   <= '0;
         full_q     <= '0;
         len_q      <= '0;
         overflow_q <= 1'b0;
         rd_state_q <= RD_IDLE;
         rd_bank_q  <= 1'b0;
         seq_q      <= '0;
         ptr_q      <= '0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
         m_first_q  <= 1'b0;
         m_last_q   <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         wr_bank_q  <= wr_bank_d;
         wr_cnt_q   <= wr_cnt_d;
         // Release of the reader's bank overrides nothing the writer sets:
         // the writer only ever closes the bank it is filling.
         full_q     <= releasing ? (full_d & ~(2'b01 << rd_bank_q)) : full_d;
         len_q      <= len_d;
         overflow_q <= overflow_d;
         rd_state_q <= rd_state_d;
         rd_bank_q  <= rd_bank_d;
         seq_q      <= seq_d;
         ptr_q      <= ptr_d;
         m_valid_q  <= m_valid_d;
         m_data_q   <= m_data_d;
         m_first_q  <= m_first_d;
         m_last_q   <= m_last_d;
      end
   end

   assign m_valid  = m_valid_q;
   assign m_data   = m_data_q;
   assign m_first  = m_first_q;
   assign m_last   = m_last_q;
   assign overflow = overflow_q;
   assign busy     = (|full_q) || (rd_state_q != RD_IDLE);

endmodule

// File: tb/tb_acq_frame_streamer.sv
module tb_acq_frame_streamer;

   localparam int DATA_W = 14;
   localparam int DEPTH  = 1024;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              wr_valid = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              frame_done = 1'b0;
   logic              m_ready = 1'b0;
   logic              m_valid, m_first, m_last, overflow, busy;
   logic [15:0]       m_data;

   int          errors = 0;
   int          checks = 0;
   int          xfer_cnt = 0;
   logic [17:0] sb [$];
   logic [4:0]  exp_seq = '0;

   logic        stall_prev = 1'b0;
   logic [17:0] prev_word = '0;
   logic [17:0] exp_word;
   logic [17:0] obs_word;

   always #5 clk = ~clk;

   acq_frame_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_first    (m_first),
      .m_last     (m_last),
      .overflow   (overflow),
      .busy       (busy)
   );

   function automatic logic [DATA_W-1:0] sval(input int base, input int step, input int i);
      return DATA_W'(base + step * i);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected words of one frame: header then samples, {first, last, data}.
   task automatic push_frame(input int n, input int base, input int step);
      logic [10:0] l;
      l = 11'(n);
      sb.push_back({1'b1, 1'b0, exp_seq, l});
      for (int i = 0; i < n; i++)
         sb.push_back({1'b0, (i == n - 1), 2'b00, sval(base, step, i)});
      exp_seq = exp_seq + 5'd1;
   endtask

   task automatic send_frame(input int n, input int base, input int step, input bit same_cycle);
      for (int i = 0; i < n; i++) begin
         wr_valid   = 1'b1;
         wr_data    = sval(base, step, i);
         frame_done = same_cycle && (i == n - 1);
         @(posedge clk); #1;
      end
      wr_valid   = 1'b0;
      frame_done = 1'b0;
      if (!same_cycle) begin
         frame_done = 1'b1;
         @(posedge clk); #1;
         frame_done = 1'b0;
      end
   endtask

   task automatic wait_drain(input int limit, input bit toggle);
      for (int i = 0; i < limit; i++) begin
         @(posedge clk); #1;
         if (toggle) m_ready = ~m_ready;
         if (sb.size() == 0 && !busy) break;
      end
      check("drain_queue_empty", sb.size(), 0);
      check("drain_busy", busy, 1'b0);
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      wr_valid   = 1'b0;
      frame_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset   = 1'b0;
      sb.delete();
      exp_seq = '0;
   endtask

   // Scoreboard and hold-stable monitor, sampled away from the rising edge.
   always @(negedge clk) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         obs_word = {m_first, m_last, m_data};
         if (stall_prev) begin
            checks++;
            assert (m_valid === 1'b1 && obs_word === prev_word) else begin
               errors++;
               $error("FAIL hold_stable: observed v=%0b w=%0h expected v=1 w=%0h",
                      m_valid, obs_word, prev_word);
            end
         end
         if (m_valid === 1'b1 && m_ready === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL extra_word: observed %0h expected no word", obs_word);
            end
            if (sb.size() != 0) begin
               exp_word = sb.pop_front();
               checks++;
               assert (obs_word === exp_word) else begin
                  errors++;
                  $error("FAIL word: observed %0h expected %0h", obs_word, exp_word);
               end
            end
            xfer_cnt++;
         end
         stall_prev = (m_valid === 1'b1) && (m_ready !== 1'b1);
         prev_word  = obs_word;
      end
   end

   initial begin
      int base_cnt;

      // Reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_first", m_first, 1'b0);
      check("rst_m_last", m_last, 1'b0);
      check("rst_m_data", m_data, 16'h0000);
      check("rst_overflow", overflow, 1'b0);
      check("rst_busy", busy, 1'b0);
      reset = 1'b0;

      // Basic frame of 4 samples, consumer always ready
      m_ready = 1'b1;
      push_frame(4, 1, 1);
      send_frame(4, 1, 1, 1'b0);
      @(posedge clk); #1;
      check("hdr_latency_valid", m_valid, 1'b1);
      check("hdr_latency_first", m_first, 1'b1);
      check("hdr_value", m_data, 16'h0004);
      wait_drain(100, 1'b0);
      check("basic_overflow", overflow, 1'b0);

      // Same frame under alternating backpressure
      m_ready = 1'b0;
      push_frame(4, 1, 1);
      send_frame(4, 1, 1, 1'b0);
      wait_drain(200, 1'b1);

      // Three back-to-back frames with the consumer stalled
      do_reset();
      m_ready = 1'b0;
      push_frame(8, 16'h100, 1);
      push_frame(8, 16'h200, 3);
      send_frame(8, 16'h100, 1, 1'b1);
      send_frame(8, 16'h200, 3, 1'b1);
      send_frame(8, 16'h300, 1, 1'b1);
      check("pp_overflow", overflow, 1'b1);
      check("pp_busy", busy, 1'b1);
      check("pp_hdr_waiting", {m_valid, m_first, m_data}, {2'b11, 16'h0008});
      m_ready = 1'b1;
      wait_drain(200, 1'b0);
      // Writer must have resumed on the released bank
      push_frame(2, 16'h55, 1);
      send_frame(2, 16'h55, 1, 1'b0);
      wait_drain(100, 1'b0);
      check("pp_overflow_sticky", overflow, 1'b1);

      // Saturation at DEPTH: 1025 writes keep 1024 samples
      do_reset();
      m_ready = 1'b1;
      push_frame(1024, 7, 5);
      send_frame(1025, 7, 5, 1'b0);
      wait_drain(3000, 1'b0);
      check("sat_overflow", overflow, 1'b1);

      // Empty frame_done produces nothing
      do_reset();
      send_frame(0, 0, 0, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      check("empty_m_valid", m_valid, 1'b0);
      check("empty_busy", busy, 1'b0);
      check("empty_overflow", overflow, 1'b0);

      // Single-sample frame, max sample value, closed in the same cycle
      push_frame(1, 16'h3fff, 0);
      send_frame(1, 16'h3fff, 0, 1'b1);
      wait_drain(100, 1'b0);

      // Reset in the middle of streaming an 8-sample frame
      do_reset();
      m_ready = 1'b1;
      push_frame(8, 16'h40, 2);
      base_cnt = xfer_cnt;
      send_frame(8, 16'h40, 2, 1'b0);
      for (int i = 0; i < 100; i++) begin
         if (xfer_cnt - base_cnt >= 3) break;
         @(posedge clk); #1;
      end
      check("mid_reached_sample3", (xfer_cnt - base_cnt >= 3), 1'b1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_m_valid", m_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_m_data", m_data, 16'h0000);
      reset = 1'b0;
      sb.delete();
      exp_seq = '0;
      push_frame(3, 9, 1);
      send_frame(3, 9, 1, 1'b0);
      wait_drain(100, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
